// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one Nios II immediate extender between two requesters.
// Define IMM26_MODE_EN to make mode 11 produce the J-type imm26<<2 form.
module imm_ext_arbiter #(
  parameter bit PRIO_RESET = 1'b0,
  parameter int COUNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [31:0]        req0_inst,
  input  logic [1:0]         req0_mode,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [31:0]        req1_inst,
  input  logic [1:0]         req1_mode,
  output logic               req1_ready,
  output logic               ext_valid,
  output logic [31:0]        ext_data,
  output logic               ext_id,
  input  logic               ext_ready,
  output logic [COUNT_W-1:0] ops_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [COUNT_W-1:0] ONE = 1;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_grant;
  logic [31:0]        r_data;
  logic               r_id;
  logic [COUNT_W-1:0] r_count;

  logic        w_can_accept;
  logic        w_g0;
  logic        w_g1;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_acc;
  logic [31:0] w_ext;

  function automatic logic [31:0] f_ext(
    input logic [31:0] inst,
    input logic [1:0]  mode
  );
    logic [15:0] imm;
    imm   = inst[21:6];
    f_ext = {{16{imm[15]}}, imm};
    case (mode)
      2'b01:   f_ext = {16'b0, imm};
      2'b10:   f_ext = {imm, 16'b0};
`ifdef IMM26_MODE_EN
      2'b11:   f_ext = {4'b0, inst[31:6], 2'b00};
`else
      2'b11:   f_ext = {{16{imm[15]}}, imm};
`endif
      default: f_ext = {{16{imm[15]}}, imm};
    endcase
  endfunction

  assign w_can_accept = ((r_state == EMPTY) | ext_ready) & ~reset;

  // On a tie, the requester that did not win last time goes next.
  assign w_g0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_g1 = req1_valid & (~req0_valid | ~r_last_grant);

  assign req0_ready = w_g0 & w_can_accept;
  assign req1_ready = w_g1 & w_can_accept;

  assign w_acc0 = req0_valid & req0_ready;
  assign w_acc1 = req1_valid & req1_ready;
  assign w_acc  = w_acc0 | w_acc1;

  assign w_ext = w_acc1 ? f_ext(req1_inst, req1_mode)
                        : f_ext(req0_inst, req0_mode);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ext_valid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) w_next = FULL;
      end
      FULL: begin
        ext_valid = 1'b1;
        if (ext_ready && !w_acc) w_next = EMPTY;
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= ~PRIO_RESET;
      r_data       <= 32'b0;
      r_id         <= 1'b0;
      r_count      <= '0;
    end else if (w_acc) begin
      r_last_grant <= w_acc1;
      r_data       <= w_ext;
      r_id         <= w_acc1;
      r_count      <= r_count + ONE;
    end
  end

  assign ext_data  = r_data;
  assign ext_id    = r_id;
  assign ops_count = r_count;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter.
// A second COUNT_W=4 instance shares the stimulus to exercise counter wrap.
module tb_imm_ext_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_inst = '0;
  logic [1:0]  req0_mode = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_inst = '0;
  logic [1:0]  req1_mode = '0;
  logic        req1_ready;
  logic        ext_valid;
  logic [31:0] ext_data;
  logic        ext_id;
  logic        ext_ready = 1'b0;
  logic [15:0] ops_count;

  logic        w4_r0;
  logic        w4_r1;
  logic        w4_valid;
  logic [31:0] w4_data;
  logic        w4_id;
  logic [3:0]  w4_count;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] INST_A = 32'h0020_0040;
  localparam logic [31:0] INST_B = 32'h0004_8D00;

  always #5 clock = ~clock;

  imm_ext_arbiter #(.PRIO_RESET(1'b0), .COUNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_inst(req0_inst),
    .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_inst(req1_inst),
    .req1_mode(req1_mode), .req1_ready(req1_ready),
    .ext_valid(ext_valid), .ext_data(ext_data),
    .ext_id(ext_id), .ext_ready(ext_ready),
    .ops_count(ops_count)
  );

  imm_ext_arbiter #(.PRIO_RESET(1'b0), .COUNT_W(4)) dut_w4 (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_inst(req0_inst),
    .req0_mode(req0_mode), .req0_ready(w4_r0),
    .req1_valid(req1_valid), .req1_inst(req1_inst),
    .req1_mode(req1_mode), .req1_ready(w4_r1),
    .ext_valid(w4_valid), .ext_data(w4_data),
    .ext_id(w4_id), .ext_ready(ext_ready),
    .ops_count(w4_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ext_valid !== 1'b0 || ext_data !== 32'h0 ||
        ext_id !== 1'b0 || ops_count !== 16'h0)
      $display("FAIL reset_state: valid=%b data=%h id=%b cnt=%0d, need 0/0/0/0",
               ext_valid, ext_data, ext_id, ops_count);
    else passed++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] exp [4];
    exp[0] = 32'hFFFF_8001;
    exp[1] = 32'h0000_8001;
    exp[2] = 32'h8001_0000;
`ifdef IMM26_MODE_EN
    exp[3] = 32'h0002_0004;
`else
    exp[3] = 32'hFFFF_8001;
`endif
    req0_valid = 1'b1;
    req0_inst  = INST_A;
    ext_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_mode = 2'(i);
      tick();
      checks++;
      if (ext_valid !== 1'b1 || ext_id !== 1'b0 || ext_data !== exp[i])
        $display("FAIL single_mode%0d: valid=%b id=%b data=%h, need 1/0/%h",
                 i, ext_valid, ext_id, ext_data, exp[i]);
      else passed++;
    end
    checks++;
    if (ops_count !== 16'd4)
      $display("FAIL single_count: got %0d, need 4", ops_count);
    else passed++;
    req0_valid = 1'b0;
    tick();
    checks++;
    if (ext_valid !== 1'b0 || ext_data !== exp[3])
      $display("FAIL single_drain: valid=%b data=%h, need 0/%h",
               ext_valid, ext_data, exp[3]);
    else passed++;
  endtask

  task automatic test_reset_mid_full();
    req1_valid = 1'b1;
    req1_inst  = INST_B;
    req1_mode  = 2'b00;
    ext_ready  = 1'b0;
    tick();
    req1_valid = 1'b0;
    checks++;
    if (ext_valid !== 1'b1 || ext_id !== 1'b1 || ext_data !== 32'h0000_1234)
      $display("FAIL midfull_load: valid=%b id=%b data=%h, need 1/1/00001234",
               ext_valid, ext_id, ext_data);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ext_valid !== 1'b0 || ext_data !== 32'h0 || ops_count !== 16'h0)
      $display("FAIL midfull_async: valid=%b data=%h cnt=%0d, need 0/0/0",
               ext_valid, ext_data, ops_count);
    else passed++;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL midfull_no_accept: r0=%b r1=%b, need 0/0",
               req0_ready, req1_ready);
    else passed++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_contention();
    req0_inst  = INST_A;
    req0_mode  = 2'b01;
    req1_inst  = INST_B;
    req1_mode  = 2'b00;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ext_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic        eid;
      logic [31:0] ed;
      eid = 1'(i % 2);
      ed  = eid ? 32'h0000_1234 : 32'h0000_8001;
      #1;
      checks++;
      if (req0_ready !== ~eid || req1_ready !== eid)
        $display("FAIL contend_grant%0d: r0=%b r1=%b, need %b/%b",
                 i, req0_ready, req1_ready, ~eid, eid);
      else passed++;
      tick();
      checks++;
      if (ext_valid !== 1'b1 || ext_id !== eid || ext_data !== ed)
        $display("FAIL contend_out%0d: valid=%b id=%b data=%h, need 1/%b/%h",
                 i, ext_valid, ext_id, ext_data, eid, ed);
      else passed++;
    end
    checks++;
    if (ops_count !== 16'd4)
      $display("FAIL contend_count: got %0d, need 4", ops_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    ext_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL bp_ready%0d: r0=%b r1=%b, need 0/0",
                 i, req0_ready, req1_ready);
      else passed++;
      tick();
      checks++;
      if (ext_valid !== 1'b1 || ext_id !== 1'b1 || ext_data !== 32'h0000_1234)
        $display("FAIL bp_hold%0d: valid=%b id=%b data=%h, need 1/1/00001234",
                 i, ext_valid, ext_id, ext_data);
      else passed++;
    end
    ext_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL bp_release_grant: r0=%b r1=%b, need 1/0",
               req0_ready, req1_ready);
    else passed++;
    tick();
    checks++;
    if (ext_valid !== 1'b1 || ext_id !== 1'b0 ||
        ext_data !== 32'h0000_8001 || ops_count !== 16'd5)
      $display("FAIL bp_release_out: valid=%b id=%b data=%h cnt=%0d, need 1/0/00008001/5",
               ext_valid, ext_id, ext_data, ops_count);
    else passed++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    checks++;
    if (ext_valid !== 1'b0)
      $display("FAIL bp_drain: valid=%b, need 0", ext_valid);
    else passed++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    req0_valid = 1'b1;
    req0_inst  = INST_A;
    req0_mode  = 2'b00;
    ext_ready  = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    req0_valid = 1'b0;
    checks++;
    if (w4_count !== 4'd1)
      $display("FAIL wrap_w4: got %0d, need 1", w4_count);
    else passed++;
    checks++;
    if (ops_count !== 16'd17)
      $display("FAIL wrap_w16: got %0d, need 17", ops_count);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_full();
    test_contention();
    test_backpressure();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
- Shares one immediate-extension datapath between two requesters: req0 = decode stage, req1 = branch/address unit.
- Extracts IMM16 from Nios II I-type bits [21:6] and extends it according to a per-request mode.
- Result is registered and returned on a single valid/ready output channel tagged with the requester ID.
- Sits between the decode/branch logic and the ALU operand mux.

Parameters:
- PRIO_RESET, 0: requester that wins the first tie after reset (0 or 1).
- COUNT_W, 16: width of the accepted-operation counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  decode-stage request.
- req0_inst  in  32  instruction word from decode.
- req0_mode  in  2  extension mode for req0.
- req0_ready  out  1  req0 accepted this cycle.
- req1_valid  in  1  branch-unit request.
- req1_inst  in  32  instruction word from branch unit.
- req1_mode  in  2  extension mode for req1.
- req1_ready  out  1  req1 accepted this cycle.
- ext_valid  out  1  result valid.
- ext_data  out  32  extended immediate.
- ext_id  out  1  requester that owns ext_data.
- ext_ready  in  1  consumer accepts result.
- ops_count  out  COUNT_W  number of accepted requests.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: ext_valid=0, ext_data=0, ext_id=0, ops_count=0.
  - Internal last_grant resets to ~PRIO_RESET.
  - Reset asserted mid-transaction discards the held result; no request is accepted while reset is high.
- FSM has two states:
  - EMPTY: ext_valid=0.
  - FULL: ext_valid=1.
- Acceptance:
  - can_accept = (state==EMPTY) | ext_ready.
  - Readiness is combinational: reqN_ready = grantN & can_accept.
  - A request is accepted when reqN_valid & reqN_ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted (round robin).
  - Neither valid: no grant.
  - last_grant updates only on an accept, never on a stalled grant.
- Transitions:
  - EMPTY with accept -> FULL.
  - FULL with ext_ready and accept -> FULL; new data loaded in the same cycle (back-to-back, no bubble).
  - FULL with ext_ready and no accept -> EMPTY.
  - FULL with !ext_ready -> FULL; ext_data and ext_id held stable.
- Latency: ext_valid rises one clock after the accept edge. Throughput is 1 result per cycle.
- Extension, with imm = inst[21:6]:
  - mode 00 (signed): {{16{imm[15]}}, imm}.
  - mode 01 (zero-extend, for andi/ori/xori): {16'b0, imm}.
  - mode 10 (high, for andhi/orhi/xorhi): {imm, 16'b0}.
  - mode 11: see Optional Feature.
- ops_count increments by 1 on every accept and wraps from 2^COUNT_W-1 to 0.
- Protocol rule: requesters hold inst and mode stable while valid & !ready. The block does not check this.
- ext_data changes only on load or reset.

Optional Feature:
- Macro: IMM26_MODE_EN.
- Defined: mode 11 selects the J-type form {4'b0, inst[31:6], 2'b00}, i.e. imm26 shifted left by 2 and zero-extended. This is used for call/jmpi.
- Undefined: mode 11 behaves exactly as mode 00 (signed).

Test Plan:
- Reset mid-FULL: load a result, assert reset with ext_ready=0 -> ext_valid=0, ext_data=0, ops_count=0 asynchronously; the first tie after release is granted to PRIO_RESET.
- Single requester: req0 inst=0x00200040 (imm=0x8001), modes 00/01/10 on consecutive cycles with ext_ready=1 -> results 0xFFFF8001, 0x00008001, 0x80010000 on cycles 1-3 with ext_id=0; ops_count=3.
- Contention: both valid every cycle, ext_ready=1, PRIO_RESET=0 -> ext_id sequence 0,1,0,1 with no bubbles.
- Backpressure: FULL with ext_ready=0 for 3 cycles and both requesting -> req0_ready=req1_ready=0, ext_data stable, last_grant unchanged. When ext_ready rises, the correct requester is accepted in that same cycle.
- Mode 11 with inst=0x00200040: with IMM26_MODE_EN -> 0x00020004; without -> 0xFFFF8001.
- Counter wrap: COUNT_W=4, 17 accepts -> ops_count=1.
